// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register-file write-back buffer.
package regfile_pkg;

    // Default widths used by the write-back buffer and its users.
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 5;

    // Architectural zero register: writes to it are consumed but never performed.
    localparam int unsigned REG_ZERO = 0;

    // One buffered write result at the default widths.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] rd;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry;

    // True when a destination address names the zero register.
    function automatic logic is_reg_zero(input logic [DEF_ADDR_W-1:0] addr);
        return addr == DEF_ADDR_W'(REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO of {rd, data} write results with per-entry visibility for
// operand probing. Data storage is unreset; every output is qualified by the
// reset-cleared valid bits so unwritten storage never reaches a port.
module wb_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push,
    input  logic [ADDR_W-1:0]                   push_rd,
    input  logic [DATA_W-1:0]                   push_data,
    input  logic                                pop,
    input  logic                                flush,
    output logic [ADDR_W-1:0]                   head_rd,
    output logic [DATA_W-1:0]                   head_data,
    output logic                                full,
    output logic                                empty,
    output logic [$clog2(DEPTH):0]              level,
    output logic [$clog2(DEPTH)-1:0]            rd_ptr,
    output logic [DEPTH-1:0]                    ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]        ent_rd,
    output logic [DEPTH-1:0][DATA_W-1:0]        ent_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] mem_rd;
    logic [DEPTH-1:0][DATA_W-1:0] mem_data;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    logic do_push;
    logic do_pop;

    // Status flags and qualified handshakes.
    always_comb begin
        full    = (level_q == LVL_W'(DEPTH));
        empty   = (level_q == '0);
        // A full buffer refuses the push even when it also pops this cycle.
        do_push = push && !full && !flush;
        do_pop  = pop && !empty && !flush;
    end

    // Next-state for pointers, valid bits and occupancy; flush wins over both.
    always_comb begin
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            valid_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_pop) begin
                valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control state register; reset clears every trace of pending writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage, written only on an accepted push; no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_rd[wr_ptr_q]   <= push_rd;
            mem_data[wr_ptr_q] <= push_data;
        end
    end

    // Head presentation and per-entry views, masked while not valid.
    always_comb begin
        head_rd   = '0;
        head_data = '0;
        if (!empty) begin
            head_rd   = mem_rd[rd_ptr_q];
            head_data = mem_data[rd_ptr_q];
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            ent_rd[i]   = valid_q[i] ? mem_rd[i] : '0;
            ent_data[i] = valid_q[i] ? mem_data[i] : '0;
        end
    end

    assign level     = level_q;
    assign rd_ptr    = rd_ptr_q;
    assign ent_valid = valid_q;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back buffer: queues execute results, retires the head
// into the register file one per cycle, and lets the issue stage probe for
// pending writes (with forwarding of the youngest matching value).
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [ADDR_W-1:0]        res_rd,
    input  logic [DATA_W-1:0]        res_data,
    input  logic                     flush,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_rd,
    output logic [DATA_W-1:0]        wr_data,
    input  logic [ADDR_W-1:0]        chk_addr1,
    input  logic [ADDR_W-1:0]        chk_addr2,
    output logic                     chk_busy1,
    output logic                     chk_busy2,
    output logic [DATA_W-1:0]        chk_data1,
    output logic [DATA_W-1:0]        chk_data2,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic                         full;
    logic                         empty;
    logic                         pop;
    logic [ADDR_W-1:0]            head_rd;
    logic [DATA_W-1:0]            head_data;
    logic [PTR_W-1:0]             rd_ptr;
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_rd;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;

    wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (res_valid),
        .push_rd   (res_rd),
        .push_data (res_data),
        .pop       (pop),
        .flush     (flush),
        .head_rd   (head_rd),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .rd_ptr    (rd_ptr),
        .ent_valid (ent_valid),
        .ent_rd    (ent_rd),
        .ent_data  (ent_data)
    );

    // Scan oldest to youngest so the last hit is the youngest match.
    function automatic logic [DATA_W:0] probe(input logic [ADDR_W-1:0] addr);
        logic             hit;
        logic [DATA_W-1:0] val;
        logic [PTR_W-1:0] idx;
        hit = 1'b0;
        val = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (addr != ADDR_W'(REG_ZERO) && ent_valid[idx] && ent_rd[idx] == addr) begin
                hit = 1'b1;
                val = ent_data[idx];
            end
        end
        return {hit, val};
    endfunction

    // Handshake and head retirement; x0 heads are popped without a write.
    always_comb begin
        res_ready = !full;
        pop       = !empty && !flush;
        wr_en     = !empty && (head_rd != ADDR_W'(REG_ZERO)) && !flush;
        wr_rd     = head_rd;
        wr_data   = head_data;
    end

    // Operand probes, from registered buffer state only.
    always_comb begin
        {chk_busy1, chk_data1} = probe(chk_addr1);
        {chk_busy2, chk_data2} = probe(chk_addr2);
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: table-driven cycles against a
// queue model of the buffer, a write scoreboard, and a mid-cycle reset case.
module tb_regfile_writeback;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              res_valid;
    logic              res_ready;
    logic [ADDR_W-1:0] res_rd;
    logic [DATA_W-1:0] res_data;
    logic              flush;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_rd;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] chk_addr1;
    logic [ADDR_W-1:0] chk_addr2;
    logic              chk_busy1;
    logic              chk_busy2;
    logic [DATA_W-1:0] chk_data1;
    logic [DATA_W-1:0] chk_data2;
    logic [2:0]        level;

    regfile_writeback #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_rd    (res_rd),
        .res_data  (res_data),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_rd     (wr_rd),
        .wr_data   (wr_data),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .chk_busy1 (chk_busy1),
        .chk_busy2 (chk_busy2),
        .chk_data1 (chk_data1),
        .chk_data2 (chk_data2),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct {
        logic              v;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              fl;
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
    } vec_t;

    ent_t mq[$];   // model of buffered entries, oldest first
    ent_t sb[$];   // writes expected at the register file, in order
    vec_t vecs[$];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Youngest matching model entry for a probe address.
    function automatic logic [DATA_W:0] model_probe(input logic [ADDR_W-1:0] a);
        logic [DATA_W:0] r;
        r = '0;
        if (a != 0)
            foreach (mq[i]) if (mq[i].rd == a) r = {1'b1, mq[i].data};
        return r;
    endfunction

    // Scoreboard: every register-file write must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL spurious_write: got rd=%0d data=%0h expected none", wr_rd, wr_data);
            end else begin
                ent_t e;
                e = sb.pop_front();
                chk("sb_wr_rd", 32'(wr_rd), 32'(e.rd));
                chk("sb_wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    // One cycle starting just after a rising edge: drive, check, advance model.
    task automatic cycle(input vec_t t);
        logic            exp_ready;
        logic            acc;
        logic [DATA_W:0] p1, p2;
        res_valid = t.v;
        res_rd    = t.rd;
        res_data  = t.data;
        flush     = t.fl;
        chk_addr1 = t.a1;
        chk_addr2 = t.a2;
        exp_ready = (mq.size() < DEPTH);
        acc       = t.v && exp_ready;
        if (t.fl) sb.delete();
        else if (acc && t.rd != 0) sb.push_back('{t.rd, t.data});
        #1;
        chk("level", 32'(level), 32'(mq.size()));
        chk("res_ready", 32'(res_ready), 32'(exp_ready));
        chk("wr_en", 32'(wr_en),
            32'(mq.size() != 0 && !t.fl && mq[0].rd != 0));
        if (mq.size() != 0) begin
            chk("wr_rd", 32'(wr_rd), 32'(mq[0].rd));
            chk("wr_data", 32'(wr_data), 32'(mq[0].data));
        end
        p1 = model_probe(t.a1);
        p2 = model_probe(t.a2);
        chk("chk_busy1", 32'(chk_busy1), 32'(p1[DATA_W]));
        chk("chk_data1", 32'(chk_data1), 32'(p1[DATA_W-1:0]));
        chk("chk_busy2", 32'(chk_busy2), 32'(p2[DATA_W]));
        chk("chk_data2", 32'(chk_data2), 32'(p2[DATA_W-1:0]));
        if (t.fl) begin
            mq.delete();
        end else begin
            if (mq.size() != 0) void'(mq.pop_front());
            if (acc) mq.push_back('{t.rd, t.data});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        res_valid = 1'b0;
        res_rd    = '0;
        res_data  = '0;
        flush     = 1'b0;
        chk_addr1 = 5'd3;
        chk_addr2 = 5'd0;

        //                v  rd     data        fl  a1     a2
        vecs.push_back('{1'b1, 5'd3,  16'h1234, 1'b0, 5'd3,  5'd0});
        vecs.push_back('{1'b0, 5'd0,  16'h0000, 1'b0, 5'd3,  5'd4});
        vecs.push_back('{1'b0, 5'd0,  16'h0000, 1'b0, 5'd3,  5'd0});
        vecs.push_back('{1'b1, 5'd0,  16'hFFFF, 1'b0, 5'd0,  5'd0});
        vecs.push_back('{1'b1, 5'd7,  16'h0042, 1'b0, 5'd0,  5'd7});
        vecs.push_back('{1'b0, 5'd0,  16'h0000, 1'b0, 5'd7,  5'd0});
        for (int i = 1; i <= 5; i++)
            vecs.push_back('{1'b1, 5'(i), 16'hA000 + 16'(i), 1'b0, 5'(i - 1), 5'(i)});
        vecs.push_back('{1'b0, 5'd0,  16'h0000, 1'b0, 5'd5,  5'd4});
        vecs.push_back('{1'b1, 5'd5,  16'h0011, 1'b0, 5'd5,  5'd0});
        vecs.push_back('{1'b1, 5'd5,  16'h0022, 1'b0, 5'd5,  5'd0});
        vecs.push_back('{1'b0, 5'd0,  16'h0000, 1'b0, 5'd5,  5'd0});
        vecs.push_back('{1'b1, 5'd9,  16'h9999, 1'b0, 5'd9,  5'd0});
        vecs.push_back('{1'b1, 5'd10, 16'hAAAA, 1'b1, 5'd9,  5'd10});
        vecs.push_back('{1'b0, 5'd0,  16'h0000, 1'b0, 5'd9,  5'd10});
        vecs.push_back('{1'b0, 5'd0,  16'h0000, 1'b0, 5'd0,  5'd0});

        // Reset values hold asynchronously, before any clock edge.
        #3;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(res_ready), 32'd1);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy1", 32'(chk_busy1), 32'd0);
        chk("rst_data1", 32'(chk_data1), 32'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) cycle(vecs[i]);

        // Reset between edges while a write is pending.
        cycle('{1'b1, 5'd12, 16'h0C0C, 1'b0, 5'd12, 5'd0});
        chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
        chk("pre_rst_busy", 32'(chk_busy1), 32'd1);
        res_valid = 1'b0;
        sb.delete();
        mq.delete();
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_ready", 32'(res_ready), 32'd1);
        chk("mid_rst_busy", 32'(chk_busy1), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            cycle('{1'b0, 5'd0, 16'h0000, 1'b0, 5'd12, 5'd0});
        cycle('{1'b1, 5'd31, 16'hBEEF, 1'b0, 5'd31, 5'd0});
        cycle('{1'b0, 5'd0, 16'h0000, 1'b0, 5'd31, 5'd0});
        cycle('{1'b0, 5'd0, 16'h0000, 1'b0, 5'd31, 5'd0});

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
